// File: rtl/mc_seq_ctrl.sv
// mc_seq_ctrl: multicycle MIPS-style control sequencer.
// Walks FETCH/DECODE and the per-instruction execute states, and drives the
// datapath control lines from the current state.
// Optional feature: define MC_ADDI_EN to add the ADDIEX/ADDIWB path for addi;
// without it, addi is reported as an illegal opcode.
module mc_seq_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output logic       pcwrite,
  output logic       pcwritecond,
  output logic       iord,
  output logic       memread,
  output logic       memwrite,
  output logic       irwrite,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       regdst,
  output logic       alusrca,
  output logic [1:0] pcsource,
  output logic [1:0] aluop,
  output logic [1:0] alusrcb,
  output logic [3:0] state,
  output logic       illegal_op
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
`ifdef MC_ADDI_EN
  localparam logic [5:0] OP_ADDI = 6'b001000;
`endif

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9
`ifdef MC_ADDI_EN
    , S_ADDIEX = 4'd10
    , S_ADDIWB = 4'd11
`endif
  } state_e;

  state_e state_q;
  state_e state_d;
  logic   op_supported;

  // Flag opcodes this build can execute; anything else is illegal in DECODE.
  always_comb begin
    op_supported = 1'b0;
    case (op)
      OP_R, OP_LW, OP_SW, OP_BEQ, OP_J: op_supported = 1'b1;
`ifdef MC_ADDI_EN
      OP_ADDI:                          op_supported = 1'b1;
`endif
      default:                          op_supported = 1'b0;
    endcase
  end

  // Next-state selection; memory states hold until mem_ready, and op is only looked at in DECODE and MEMADR.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
`ifdef MC_ADDI_EN
          OP_ADDI:      state_d = S_ADDIEX;
`endif
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
`ifdef MC_ADDI_EN
      S_ADDIEX: state_d = S_ADDIWB;
      S_ADDIWB: state_d = S_FETCH;
`endif
      default:  state_d = S_FETCH;
    endcase
  end

  // State register with synchronous reset back to FETCH.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Control decode from the current state; reset blanks every control so no write escapes mid-instruction.
  always_comb begin
    pcwrite     = 1'b0;
    pcwritecond = 1'b0;
    iord        = 1'b0;
    memread     = 1'b0;
    memwrite    = 1'b0;
    irwrite     = 1'b0;
    memtoreg    = 1'b0;
    regwrite    = 1'b0;
    regdst      = 1'b0;
    alusrca     = 1'b0;
    pcsource    = 2'b00;
    aluop       = 2'b00;
    alusrcb     = 2'b00;
    illegal_op  = 1'b0;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          memread = 1'b1;
          alusrcb = 2'b01;
          irwrite = mem_ready;
          pcwrite = mem_ready;
        end
        S_DECODE: begin
          alusrcb    = 2'b11;
          illegal_op = !op_supported;
        end
        S_MEMADR: begin
          alusrca = 1'b1;
          alusrcb = 2'b10;
        end
        S_MEMRD: begin
          memread = 1'b1;
          iord    = 1'b1;
        end
        S_MEMWB: begin
          regwrite = 1'b1;
          memtoreg = 1'b1;
        end
        S_MEMWR: begin
          memwrite = 1'b1;
          iord     = 1'b1;
        end
        S_EXEC: begin
          alusrca = 1'b1;
          aluop   = 2'b10;
        end
        S_ALUWB: begin
          regwrite = 1'b1;
          regdst   = 1'b1;
        end
        S_BRANCH: begin
          alusrca     = 1'b1;
          aluop       = 2'b01;
          pcwritecond = 1'b1;
          pcsource    = 2'b01;
        end
        S_JUMP: begin
          pcwrite  = 1'b1;
          pcsource = 2'b10;
        end
`ifdef MC_ADDI_EN
        S_ADDIEX: begin
          alusrca = 1'b1;
          alusrcb = 2'b10;
        end
        S_ADDIWB: begin
          regwrite = 1'b1;
        end
`endif
        default: begin
        end
      endcase
    end
  end

  assign state = state_q;

endmodule

// File: doc/mc_seq_ctrl.md
MC_SEQ_CTRL -- requirements
Module: mc_seq_ctrl

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 The ports SHALL be as follows:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- op  in  6  instruction opcode from the IR
- mem_ready  in  1  memory completes the current access this cycle
- pcwrite, pcwritecond, iord, memread, memwrite, irwrite, memtoreg, regwrite, regdst, alusrca  out  1 each  datapath controls
- pcsource  out  2  PC mux select
- aluop  out  2  ALU decoder class
- alusrcb  out  2  ALU B mux select
- state  out  4  current state, for debug
- illegal_op  out  1  one-cycle pulse on an unsupported opcode

Function
REQ-004 State SHALL be a 4-bit register that updates on the rising edge of clk.
REQ-005 The encoded states SHALL be: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11.
REQ-006 The opcodes SHALL be: R=000000, lw=100011, sw=101011, beq=000100, j=000010, addi=001000.
REQ-007 FETCH->DECODE SHALL occur only when mem_ready=1; otherwise the block stays in FETCH.
REQ-008 DECODE SHALL branch on op: lw/sw->MEMADR, R->EXEC, beq->BRANCH, j->JUMP, addi->ADDIEX; any other op->FETCH with illegal_op=1 for that cycle.
REQ-009 MEMADR SHALL go to MEMRD for lw and to MEMWR for sw.
REQ-010 MEMRD->MEMWB and MEMWR->FETCH SHALL occur only when mem_ready=1; otherwise the block holds.
REQ-011 The remaining transitions SHALL be: MEMWB->FETCH, EXEC->ALUWB, ALUWB->FETCH, BRANCH->FETCH, JUMP->FETCH, ADDIEX->ADDIWB, ADDIWB->FETCH.
REQ-012 In FETCH the outputs SHALL be: memread=1, iord=0, alusrca=0, alusrcb=01, aluop=00, pcsource=00; irwrite=pcwrite=mem_ready.
REQ-013 In DECODE the outputs SHALL be: alusrca=0, alusrcb=11, aluop=00.
REQ-014 In MEMADR and ADDIEX the outputs SHALL be: alusrca=1, alusrcb=10, aluop=00.
REQ-015 In MEMRD the outputs SHALL be: memread=1, iord=1.
REQ-016 In MEMWR the outputs SHALL be: memwrite=1, iord=1.
REQ-017 memread and memwrite SHALL be held for every wait cycle.
REQ-018 In MEMWB the outputs SHALL be: regwrite=1, memtoreg=1, regdst=0.
REQ-019 In EXEC the outputs SHALL be: alusrca=1, alusrcb=00, aluop=10.
REQ-020 In ALUWB the outputs SHALL be: regwrite=1, regdst=1, memtoreg=0.
REQ-021 In BRANCH the outputs SHALL be: alusrca=1, alusrcb=00, aluop=01, pcwritecond=1, pcsource=01.
REQ-022 In JUMP the outputs SHALL be: pcwrite=1, pcsource=10.
REQ-023 In ADDIWB the outputs SHALL be: regwrite=1, regdst=0, memtoreg=0.
REQ-024 Any output not listed for a state SHALL be 0.
REQ-025 Unencoded states 12-15 SHALL drive all controls 0 and go to FETCH next cycle.
REQ-026 op SHALL be sampled only in DECODE and MEMADR; op changes in other states SHALL have no effect.
REQ-027 Instruction latencies from FETCH accept SHALL be: lw 5 cycles, sw/R/addi 4, beq/j 3, plus memory wait cycles.

Reset
REQ-028 When reset=1 at a clock edge, state SHALL become FETCH regardless of current state or mem_ready.
REQ-029 While reset=1, all outputs except state SHALL be forced to 0 combinationally, including memwrite and regwrite mid-instruction.
REQ-030 After reset deasserts, the first cycle SHALL be FETCH with memread=1.

Configuration
REQ-031 Macro MC_ADDI_EN SHALL control addi support.
REQ-032 With MC_ADDI_EN defined, addi SHALL execute via ADDIEX/ADDIWB.
REQ-033 Without MC_ADDI_EN, ADDIEX/ADDIWB SHALL be absent, and addi SHALL be treated as illegal (DECODE->FETCH, illegal_op=1).

Verification
REQ-034 Reset, then lw with mem_ready=1 always -> states 0,1,2,3,4,0; regwrite=1 and memtoreg=1 only in state 4.
REQ-035 sw with mem_ready low for 3 cycles in MEMWR -> memwrite=1 for 4 consecutive cycles, then state 0.
REQ-036 FETCH with mem_ready=0 for 2 cycles then 1 -> irwrite/pcwrite=0,0,1; state 1 after the third cycle.
REQ-037 op=111111 in DECODE -> illegal_op=1 for one cycle, state 0 next, no regwrite/memwrite.
REQ-038 reset asserted in MEMWR -> memwrite=0 in that same cycle, state 0 next edge.
REQ-039 addi with and without MC_ADDI_EN -> states 1,10,11,0 with regwrite in 11, versus 1,0 with illegal_op=1.
